// File: rtl/serdes_pkg.sv
// serdes_pkg: definitions shared by the serial link transmitter (serializer)
// and receiver (deserializer), so both ends agree on word size, state
// encoding and bit-counter width.
package serdes_pkg;

  localparam int DATA_SIZE_DEF = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } serdes_state_t;

  // The counter must be able to hold the value dataSize itself,
  // not just dataSize-1.
  function automatic int cntWidth(input int dataSize);
    return $clog2(dataSize + 1);
  endfunction

endpackage

// File: rtl/serializer.sv
// serializer: parallel-in, serial-out transmitter for the serial link.
// Accepts a DATA_SIZE-bit word on a valid/ready handshake and shifts it out
// MSB first, one bit per enabled clock, framed by oLoading.
//
// Ports:
//   iClk       system clock (same domain as the receiver)
//   iRst       asynchronous, active-low reset
//   iEn        clock qualifier; nothing changes on edges with iEn=0
//   iValid     upstream has a word on iData
//   iData      parallel word, sampled only on the accept edge
//   oReady     word can be accepted this cycle (combinational)
//   oData_out  serial data, MSB first
//   oLoading   high while oData_out carries a frame bit
//   oDone_flag one-enabled-cycle end-of-frame pulse
//
// state | meaning
// IDLE  | line idle, oReady=1, outputs low
// SHIFT | frame on the line; cnt = bits presented so far (1..DATA_SIZE)
module serializer
  import serdes_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iValid,
  input  logic [DATA_SIZE-1:0] iData,
  output logic                 oReady,
  output logic                 oData_out,
  output logic                 oLoading,
  output logic                 oDone_flag
);

  localparam int             CW       = cntWidth(DATA_SIZE);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DATA_SIZE);

  serdes_state_t        state;
  logic [DATA_SIZE-1:0] shiftReg;
  logic [CW-1:0]        cnt;
  logic                 lastBit;

  // The last bit is on the line when cnt reaches DATA_SIZE; a new word may be
  // accepted on that edge so back-to-back frames have no gap.
  assign lastBit = (state == SHIFT) && (cnt == CNT_FULL);
  assign oReady  = (state == IDLE) || lastBit;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= IDLE;
      shiftReg   <= '0;
      cnt        <= '0;
      oData_out  <= 1'b0;
      oLoading   <= 1'b0;
      oDone_flag <= 1'b0;
    end else if (iEn) begin
      oDone_flag <= 1'b0;
      if (state == IDLE || lastBit) begin
        if (lastBit) begin
          oDone_flag <= 1'b1;
        end
        if (iValid) begin
          // MSB goes straight to the line; the rest waits in shiftReg.
          oData_out <= iData[DATA_SIZE-1];
          shiftReg  <= {iData[DATA_SIZE-2:0], 1'b0};
          cnt       <= CW'(1);
          oLoading  <= 1'b1;
          state     <= SHIFT;
        end else begin
          oData_out <= 1'b0;
          oLoading  <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
      end else begin
        oData_out <= shiftReg[DATA_SIZE-1];
        shiftReg  <= {shiftReg[DATA_SIZE-2:0], 1'b0};
        cnt       <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed bench for serializer. A 4-bit and an 8-bit
// instance share clock, reset and enable; a small receiver model on each
// samples oData_out on every enabled edge where oLoading is high, mirroring
// the deserializer, so received words can be checked at each oDone_flag.
module tb_serializer;

  logic       iClk;
  logic       iRst;
  logic       iEn;
  logic       iValid;
  logic [3:0] iData;
  logic       oReady;
  logic       oData_out;
  logic       oLoading;
  logic       oDone_flag;

  logic       iValid8;
  logic [7:0] iData8;
  logic       oReady8;
  logic       oData_out8;
  logic       oLoading8;
  logic       oDone_flag8;

  logic [3:0] rx4;
  logic [7:0] rx8;

  int nChecks = 0;
  int nPass   = 0;

  serializer #(.DATA_SIZE(4)) dut4 (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oData_out(oData_out), .oLoading(oLoading),
    .oDone_flag(oDone_flag)
  );

  serializer #(.DATA_SIZE(8)) dut8 (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iValid(iValid8), .iData(iData8),
    .oReady(oReady8), .oData_out(oData_out8), .oLoading(oLoading8),
    .oDone_flag(oDone_flag8)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Receiver models: shift in the bit that is on the line before the edge.
  always @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rx4 <= '0;
      rx8 <= '0;
    end else if (iEn) begin
      if (oLoading)  rx4 <= {rx4[2:0], oData_out};
      if (oLoading8) rx8 <= {rx8[6:0], oData_out8};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    logic [7:0] stream;
    logic [3:0] w4;
    logic [7:0] w8;
    logic       seen4, seen8, prev4, prev8;
    int         budget;

    iRst = 1'b0; iEn = 1'b1; iValid = 1'b0; iData = '0;
    iValid8 = 1'b0; iData8 = '0;

    // Reset values
    #3;
    check("rst_data", oData_out, 0);
    check("rst_loading", oLoading, 0);
    check("rst_done", oDone_flag, 0);
    #9;
    iRst = 1'b1;
    #1;
    check("rst_ready", oReady, 1);

    // 1: single word 1011
    iValid = 1'b1; iData = 4'b1011;
    tick();
    iValid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      check("t1_loading", oLoading, 1);
      check("t1_bit", oData_out, iData[k]);
      check("t1_nodone", oDone_flag, 0);
      tick();
    end
    check("t1_done", oDone_flag, 1);
    check("t1_loading_end", oLoading, 0);
    check("t1_data_end", oData_out, 0);
    check("t1_ready", oReady, 1);
    check("t1_rx", rx4, 4'b1011);
    tick();
    check("t1_done_clear", oDone_flag, 0);

    // 2: back-to-back A then 5, iData changed right after accept of A
    stream = 8'b1010_0101;
    iValid = 1'b1; iData = 4'hA;
    tick();
    iData = 4'h5;
    for (int i = 0; i < 8; i++) begin
      check("t2_loading", oLoading, 1);
      check("t2_bit", oData_out, stream[7-i]);
      check("t2_done", oDone_flag, (i == 4) ? 1 : 0);
      if (i == 4) begin
        check("t2_rx_a", rx4, 4'hA);
        iValid = 1'b0;
      end
      tick();
    end
    check("t2_done2", oDone_flag, 1);
    check("t2_loading_end", oLoading, 0);
    check("t2_rx_5", rx4, 4'h5);
    tick();

    // 3: iEn toggling during frame C
    iValid = 1'b1; iData = 4'hC;
    tick();
    iValid = 1'b0;
    check("t3_b3", oData_out, 1);
    iEn = 1'b0; tick();
    check("t3_hold_b3", oData_out, 1);
    check("t3_hold_ld", oLoading, 1);
    iEn = 1'b1; tick();
    check("t3_b2", oData_out, 1);
    iEn = 1'b0; tick();
    check("t3_hold_b2", oData_out, 1);
    iEn = 1'b1; tick();
    check("t3_b1", oData_out, 0);
    iEn = 1'b0; tick();
    check("t3_hold_b1", oData_out, 0);
    check("t3_hold_ld2", oLoading, 1);
    iEn = 1'b1; tick();
    check("t3_b0", oData_out, 0);
    check("t3_nodone", oDone_flag, 0);
    tick();
    check("t3_done", oDone_flag, 1);
    check("t3_rx", rx4, 4'hC);
    iEn = 1'b0; tick();
    check("t3_done_hold", oDone_flag, 1);
    iEn = 1'b1; tick();
    check("t3_done_clear", oDone_flag, 0);

    // 4: reset mid-frame of F, then clean word 3
    iValid = 1'b1; iData = 4'hF;
    tick();
    iValid = 1'b0;
    tick();
    #2;
    iRst = 1'b0;
    #1;
    check("t4_rst_data", oData_out, 0);
    check("t4_rst_loading", oLoading, 0);
    check("t4_rst_done", oDone_flag, 0);
    #1;
    iRst = 1'b1;
    #1;
    check("t4_ready", oReady, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_no_done", oDone_flag, 0);
    end
    iValid = 1'b1; iData = 4'h3;
    tick();
    iValid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      check("t4_bit", oData_out, iData[k]);
      tick();
    end
    check("t4_done", oDone_flag, 1);
    check("t4_rx", rx4, 4'h3);
    tick();

    // 5: word 9 offered while cnt=2 of frame 6
    iValid = 1'b1; iData = 4'h6;
    tick();
    iValid = 1'b0;
    tick();
    iValid = 1'b1; iData = 4'h9;
    #1;
    check("t5_busy_ready", oReady, 0);
    tick();
    check("t5_b1", oData_out, 1);
    check("t5_busy_ready2", oReady, 0);
    tick();
    check("t5_b0", oData_out, 0);
    check("t5_last_ready", oReady, 1);
    tick();
    iValid = 1'b0;
    check("t5_done6", oDone_flag, 1);
    check("t5_loading", oLoading, 1);
    check("t5_rx6", rx4, 4'h6);
    check("t5_9b3", oData_out, 1);
    tick();
    check("t5_9b2", oData_out, 0);
    tick();
    check("t5_9b1", oData_out, 0);
    tick();
    check("t5_9b0", oData_out, 1);
    tick();
    check("t5_done9", oDone_flag, 1);
    check("t5_rx9", rx4, 4'h9);
    tick();

    // 6: loopback with random words on both widths, random enable gaps
    for (int n = 0; n < 6; n++) begin
      w4 = 4'($urandom);
      w8 = 8'($urandom);
      iEn = 1'b1;
      iValid = 1'b1; iData = w4;
      iValid8 = 1'b1; iData8 = w8;
      tick();
      iValid = 1'b0; iValid8 = 1'b0;
      seen4 = 1'b0; seen8 = 1'b0;
      prev4 = oDone_flag; prev8 = oDone_flag8;
      budget = 60;
      while (!(seen4 && seen8) && budget > 0) begin
        iEn = ($urandom_range(0, 3) != 0);
        tick();
        budget--;
        if (oDone_flag && !prev4) begin
          check("t6_rx4", rx4, w4);
          seen4 = 1'b1;
        end
        if (oDone_flag8 && !prev8) begin
          check("t6_rx8", rx8, w8);
          seen8 = 1'b1;
        end
        prev4 = oDone_flag; prev8 = oDone_flag8;
      end
      check("t6_frames_seen", {seen4, seen8}, 2'b11);
      iEn = 1'b1;
      tick();
      tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
Parallel-in, serial-out transmitter for the team's serial link. It is the transmit end of the deserializer block.
- Accepts a DATA_SIZE-bit word through a valid/ready handshake.
- Shifts the word out MSB-first, one bit per enabled clock, on oData_out.
- Drives a framing flag oLoading that connects directly to the receiver's iLoading input.
- Pulses oDone_flag when a frame completes.

Parameters:
DATA_SIZE, 4, word width in bits (legal range >= 2).

Ports:
iClk  input  1  system clock (half_clock domain, same as the receiver).
iRst  input  1  reset; asynchronous, active-low.
iEn  input  1  clock qualifier; no state changes on edges where iEn=0.
iValid  input  1  upstream has a word on iData.
iData  input  DATA_SIZE  parallel word; sampled only on the accept edge.
oReady  output  1  block can accept a word this cycle (combinational).
oData_out  output  1  serial data, MSB first, registered.
oLoading  output  1  high while oData_out carries a valid frame bit, registered.
oDone_flag  output  1  end-of-frame pulse, registered.

Behaviour:
- Reset (iRst=0, asynchronous): all state and outputs go to their reset values immediately.
  - state=IDLE, shift register=0, bit counter=0.
  - oData_out=0, oLoading=0, oDone_flag=0.
  - oReady=1 once reset is released.
- Reset mid-frame: the frame is abandoned and no oDone_flag is produced.
- All registers update only on posedge iClk with iEn=1. With iEn=0, every output holds its value.
- Internal state: shift register [DATA_SIZE-1:0] and bit counter cnt of width $clog2(DATA_SIZE+1).
- States: IDLE and SHIFT.
- oReady = (state==IDLE) || (state==SHIFT && cnt==DATA_SIZE).
- Accept edge: enabled edge with iValid && oReady.
  - oData_out <= iData[DATA_SIZE-1].
  - shift register <= iData<<1.
  - cnt <= 1, oLoading <= 1, state <= SHIFT.
- SHIFT with cnt<DATA_SIZE, on each enabled edge:
  - oData_out <= shift register MSB.
  - shift register <<= 1, shifting in 0.
  - cnt++.
- SHIFT with cnt==DATA_SIZE (last bit on the line), on the next enabled edge:
  - oDone_flag <= 1.
  - If iValid=1: perform the accept actions. This gives back-to-back frames with no gap; oLoading stays 1.
  - Otherwise: oLoading <= 0, oData_out <= 0, state <= IDLE, cnt <= 0.
- oDone_flag is high for exactly one enabled cycle. It clears on the following enabled edge unless another frame ends on that edge, which cannot happen for DATA_SIZE >= 2.
- Latency and framing:
  - oLoading is high for exactly DATA_SIZE enabled cycles per word, immediately after the accept edge.
  - Bit k (MSB first) is stable on oData_out through the (k+1)th enabled edge after accept. The receiver samples on that edge.
- iValid while busy with cnt<DATA_SIZE: ignored (oReady=0). The word is not captured and upstream must hold it.
- iData changes after the accept edge: no effect on the frame in flight.
- iEn low mid-frame: the frame stretches. Bit count and order are unchanged, and oLoading stays high.

Decomposition:
- Shared package serdes_pkg holds:
  - DATA_SIZE default.
  - State encoding localparams: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - The shared counter-width function, so the deserializer and serializer agree.
- Single module; no natural sub-module. Shift register and counter stay inline.

Test Plan:
1. DATA_SIZE=4, iEn=1, iData=4'b1011 with a 1-cycle iValid pulse:
   - oLoading high for 4 cycles with oData_out=1,0,1,1.
   - oDone_flag pulses 1 cycle later; oReady returns to 1.
2. Back-to-back words 4'hA then 4'h5 with iValid held:
   - oLoading stays continuously high for 8 cycles; serial stream 1010_0101.
   - oDone_flag pulses twice, 4 cycles apart.
3. iEn toggling 1,0,1,0 during a 4'hC frame:
   - oData_out and oLoading hold while iEn=0; bit sequence 1,1,0,0 is preserved.
   - oDone_flag is asserted only after the 4th enabled edge.
4. iRst=0 asserted after 2 bits of 4'hF, between clock edges:
   - Outputs go to 0 immediately, with no oDone_flag.
   - After release, oReady=1 and a new word 4'h3 transmits cleanly.
5. iValid with iData=4'h9 asserted while cnt=2 of a prior frame:
   - oReady=0 and the word is not taken.
   - With iValid held, 4'h9 is accepted on the last-bit edge and transmitted next.
6. Loopback into the deserializer (same iEn and iClk) with random words, DATA_SIZE=4 and 8: the received oData equals the transmitted word for every frame.
